// File: rtl/ibus_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : ibus_mem_responder_if
// Description : Request/stall bus bundle between a naive_mips master and the
//               on-chip memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface ibus_mem_responder_if;
  logic [31:0] bus_address;
  logic [3:0]  bus_byteenable;
  logic        bus_read;
  logic        bus_write;
  logic [31:0] bus_wrdata;
  logic [31:0] bus_rddata;
  logic        bus_stall;

  modport master (
    output bus_address, bus_byteenable, bus_read, bus_write, bus_wrdata,
    input  bus_rddata, bus_stall
  );

  modport slave (
    input  bus_address, bus_byteenable, bus_read, bus_write, bus_wrdata,
    output bus_rddata, bus_stall
  );
endinterface
`default_nettype wire

// File: rtl/ibus_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : ibus_mem_responder
// Description : Word-addressed on-chip memory slave for the request/stall bus.
//               Serves reads and byte-enabled writes after WAIT_CYCLE wait
//               cycles. Optional protocol checker enabled by the macro
//               IBUS_RESPONDER_PROT_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ibus_mem_responder #(
  parameter int WAIT_CYCLE = 4,
  parameter int ADDR_WIDTH = 13
) (
  input  logic                clk,
  input  logic                rst_n,
  ibus_mem_responder_if.slave bus,
  output logic                prot_err
);

  localparam int c_IDX_W = ADDR_WIDTH - 2;
  localparam int c_DEPTH = 1 << c_IDX_W;
  localparam int c_CNT_W = (WAIT_CYCLE > 0) ? $clog2(WAIT_CYCLE + 1) : 1;
  localparam logic [c_CNT_W-1:0] c_WAIT_LAST =
    c_CNT_W'((WAIT_CYCLE > 0) ? WAIT_CYCLE - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [c_CNT_W-1:0]   r_wait_cnt;
  logic [31:0]          r_addr;
  logic [31:0]          r_wrdata;
  logic [3:0]           r_be;
  logic                 r_is_write;
  logic [31:0]          r_rddata;
  logic                 r_prot_err;

  logic                 w_req;
  logic                 w_done;
  logic                 w_last;
  logic                 w_abort;
  logic                 w_capture;
  logic                 w_commit;
  logic [c_IDX_W-1:0]   w_idx;
  logic [3:0]           w_be;
  logic [31:0]          w_wdata;
  logic                 w_is_write;

  logic [31:0]          rom [c_DEPTH];

  assign w_req          = bus.bus_read | bus.bus_write;
  assign w_done         = (r_state == ST_DONE);
  assign w_last         = (r_wait_cnt == c_WAIT_LAST);
  assign bus.bus_stall  = w_req & ~w_done;
  assign bus.bus_rddata = r_rddata;
  assign prot_err       = r_prot_err;

`ifdef IBUS_RESPONDER_PROT_CHECK_EN
  // The master must hold the same request for the whole wait period.
  assign w_abort = (r_state == ST_BUSY) &&
                   (!w_req || (bus.bus_address != r_addr));
`else
  logic w_unused_addr_bits;
  assign w_abort = 1'b0;
  // Only the word-index bits are decoded; the rest alias.
  assign w_unused_addr_bits = ^{bus.bus_address[31:ADDR_WIDTH], bus.bus_address[1:0],
                                r_addr[31:ADDR_WIDTH], r_addr[1:0]};
`endif

  // With zero wait cycles the access completes on the capture edge, so the
  // completing access comes straight from the bus instead of the latches.
  assign w_idx      = (r_state == ST_IDLE) ? bus.bus_address[ADDR_WIDTH-1:2]
                                           : r_addr[ADDR_WIDTH-1:2];
  assign w_be       = (r_state == ST_IDLE) ? bus.bus_byteenable : r_be;
  assign w_wdata    = (r_state == ST_IDLE) ? bus.bus_wrdata : r_wrdata;
  assign w_is_write = (r_state == ST_IDLE) ? bus.bus_write : r_is_write;

  // Next-state logic plus capture/commit strobes.
  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_capture = 1'b1;
          if (WAIT_CYCLE == 0) begin
            w_next_state = ST_DONE;
            w_commit     = 1'b1;
          end else begin
            w_next_state = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (w_abort) begin
          w_next_state = ST_IDLE;
        end else if (w_last) begin
          w_next_state = ST_DONE;
          w_commit     = 1'b1;
        end
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Request latches, wait counter, read data and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
      r_addr     <= '0;
      r_wrdata   <= '0;
      r_be       <= '0;
      r_is_write <= 1'b0;
      r_rddata   <= '0;
      r_prot_err <= 1'b0;
    end else begin
      if (w_capture) begin
        r_addr     <= bus.bus_address;
        r_wrdata   <= bus.bus_wrdata;
        r_be       <= bus.bus_byteenable;
        r_is_write <= bus.bus_write;
        r_wait_cnt <= '0;
      end else if (r_state == ST_BUSY) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      // Writes also return the pre-write word (read-before-write).
      if (w_commit) begin
        r_rddata <= rom[w_idx];
      end
      if (w_abort) begin
        r_prot_err <= 1'b1;
      end
    end
  end

  // Memory write port; contents are never cleared, reset only blocks writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
    end else if (w_commit && w_is_write) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          rom[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
        end
      end
    end
  end

`ifdef IBUS_RESPONDER_PROT_CHECK_EN
`ifndef SYNTHESIS
  // Simulation notice when an access is aborted by the checker.
  always_ff @(posedge clk) begin
    if (w_abort) begin
      $display("bus transaction prematurely ended");
    end
  end
`endif
`endif

endmodule
`default_nettype wire

// File: doc/ibus_mem_responder.md
# ibus_mem_responder

Synthesizable slave for the naive_mips instruction/data bus request–stall protocol. It holds a word-addressed on-chip memory and serves reads and byte-enabled writes after a programmable number of wait cycles. It drives `stall` so the CPU holds its request until the access completes. It replaces the behavioural wait-state model in simulation and serves as the boot ROM/RAM slot on FPGA builds.

## Interface
Parameters:
- `WAIT_CYCLE`, default 4: wait cycles inserted between request capture and completion; 0 is legal.
- `ADDR_WIDTH`, default 13: byte-address bits decoded; memory depth is 2^(ADDR_WIDTH-2) words of 32 bits.

Ports:
- `clk`  in  1  system clock; everything is sampled on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `bus_address`  in  32  byte address; word index is `bus_address[ADDR_WIDTH-1:2]`. Upper bits and `[1:0]` are ignored, so addresses alias.
- `bus_byteenable`  in  4  write byte lanes; bit i enables byte lane [8i+7:8i].
- `bus_read`  in  1  read request, held by the master until `bus_stall` is low.
- `bus_write`  in  1  write request, held by the master until `bus_stall` is low.
- `bus_wrdata`  in  32  write data.
- `bus_rddata`  out  32  registered read data, valid in the completion cycle and held until the next completion.
- `bus_stall`  out  1  combinational: `(bus_read|bus_write) & ~done`.
- `prot_err`  out  1  sticky protocol-violation flag.

## Operation
FSM states: IDLE, BUSY, DONE. A `wait_cnt` counter is sized to hold WAIT_CYCLE.
- **IDLE:** `done`=0. If `bus_read|bus_write` is high at a posedge:
  - latch address, byteenable, wrdata and op (write wins if both are asserted);
  - clear `wait_cnt`;
  - go to BUSY, or directly to DONE if WAIT_CYCLE=0.
- **BUSY:** `wait_cnt` increments each posedge. When `wait_cnt==WAIT_CYCLE-1`, the next posedge goes to DONE.
- **Entering DONE (same posedge):**
  - Read: `bus_rddata` ← mem[latched index].
  - Write: lanes enabled in the latched byteenable are written. `bus_rddata` ← the pre-write word (read-before-write).
- **DONE:** `done`=1, so `bus_stall`=0 and the master retires the access at the next posedge. The FSM then returns to IDLE unconditionally, and a new request is captured from IDLE. There is no back-to-back capture in DONE.
- **Memory:** the array is not reset. Simulation preloads it hierarchically through the array `rom`, using word-indexed `$readmemh`.
- **Reset asserted mid-operation:** immediately forces IDLE with `wait_cnt`=0, `bus_rddata`=0 and `prot_err`=0. Any write in flight is dropped.

## Timing
- Reset values: state IDLE, `bus_rddata`=32'h0, `prot_err`=0, `done`=0. `bus_stall` follows the request inputs, so it is 1 whenever a request is present.
- Access latency from the first request cycle (cycle 0) to the `bus_stall`=0 cycle: WAIT_CYCLE+1 cycles. Each access occupies WAIT_CYCLE+2 cycles including the return to IDLE.
- With WAIT_CYCLE=4: request in cycle 0, BUSY in cycles 1–4, DONE in cycle 5 (data valid, stall low), IDLE in cycle 6.
- The slave never completes an access without a request captured in IDLE.
- `bus_stall` is 0 in IDLE when no request is present.

## Configuration
Macro `IBUS_RESPONDER_PROT_CHECK_EN`.
- **Defined:** in BUSY, the block checks each cycle for two violations:
  - `bus_read|bus_write` dropped, or
  - `bus_address` differs from the latched value.

  On either violation it sets `prot_err` (sticky until reset), aborts to IDLE without writing memory, and leaves `bus_rddata` unchanged. Under `ifndef SYNTHESIS` it also emits `$display("bus transaction prematurely ended")`.
- **Undefined:** no checking. The access always completes with the latched values, and `prot_err` is tied 0.

## Test plan
- **Reset values:** assert `rst_n`=0 with `bus_read`=1 → `bus_rddata`=0, `prot_err`=0, `bus_stall`=1, state IDLE.
- **Timed read:** WAIT_CYCLE=4, preload mem[0]=32'h3C08_8000, read address 32'h8000_0000 in cycle 0 → `bus_stall`=1 in cycles 0–4, 0 in cycle 5 with `bus_rddata`=32'h3C08_8000.
- **Byte-enabled write:** write 32'hAABB_CCDD with byteenable 4'b0101 to a word holding 32'h1122_3344, then read it back → 32'h11BB_33DD. The write cycle returns 32'h1122_3344.
- **Zero-wait back-to-back reads:** WAIT_CYCLE=0, reads at addresses 0x0 and 0x4 → each completes in the cycle after capture; stall pattern 1,0,1,0; data matches the preload.
- **Aliasing and async reset:** ADDR_WIDTH=13, read 32'h8000_2004 → returns mem[1]. Drop `rst_n` during BUSY → FSM in IDLE, and a following write does not commit a stale value.
- **Protocol check (macro defined):** drop `bus_read` in BUSY cycle 2 → `prot_err`=1 and stays 1, memory unchanged. With the macro undefined the same stimulus completes normally and `prot_err`=0.
